// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline boundary register for the RISC-V core.
// Carries a control bundle, a data bundle and a valid bit through DEPTH
// register stages. Hazard-unit flush/stall and bubble masking are handled
// here, and saturating stall/flush event counters are kept on the side.
module pipe_stage_reg #(
    parameter int CTRL_W    = 4,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 1,
    parameter     KILL_MASK = 4'b1001,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              cnt_clr,
    output logic              valid_out,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    generate
        if (DEPTH < 1 || DEPTH > 4) begin : gDepthChk
            $error("pipe_stage_reg: DEPTH must be within 1..4");
        end
        if ($bits(KILL_MASK) != CTRL_W) begin : gMaskChk
            $error("pipe_stage_reg: KILL_MASK width must equal CTRL_W");
        end
    endgenerate

    localparam logic [CTRL_W-1:0] killMask = CTRL_W'(KILL_MASK);

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    logic              vldP  [DEPTH];
    logic [CTRL_W-1:0] ctrlP [DEPTH];
    logic [DATA_W-1:0] dataP [DEPTH];

    logic              srcVld  [DEPTH];
    logic [CTRL_W-1:0] srcCtrl [DEPTH];
    logic [DATA_W-1:0] srcData [DEPTH];

    // Source of each stage: stage 0 takes the (bubble-masked) inputs, later
    // stages take their predecessor, which is already masked.
    always_comb begin
        srcVld[0]  = valid_in;
        srcCtrl[0] = valid_in ? ctrl_in : (ctrl_in & ~killMask);
        srcData[0] = data_in;
        for (int k = 1; k < DEPTH; k++) begin
            srcVld[k]  = vldP[k-1];
            srcCtrl[k] = ctrlP[k-1];
            srcData[k] = dataP[k-1];
        end
    end

    // Stage registers: flush advances killed slots, stall holds, else advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                vldP[k]  <= 1'b0;
                ctrlP[k] <= '0;
                dataP[k] <= '0;
            end
        end else if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                vldP[k]  <= 1'b0;
                ctrlP[k] <= srcCtrl[k] & ~killMask;
                dataP[k] <= srcData[k];
            end
        end else if (!stall) begin
            for (int k = 0; k < DEPTH; k++) begin
                vldP[k]  <= srcVld[k];
                ctrlP[k] <= srcCtrl[k];
                dataP[k] <= srcData[k];
            end
        end
    end

    // Event counters: clear wins over any increment in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (flush) begin
            flush_cnt <= satInc(flush_cnt);
        end else if (stall) begin
            stall_cnt <= satInc(stall_cnt);
        end
    end

    assign valid_out = vldP[DEPTH-1];
    assign ctrl_out  = ctrlP[DEPTH-1];
    assign data_out  = dataP[DEPTH-1];

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: three instances (DEPTH 1/2/3, the last with
// 2-bit counters) share one stimulus stream and are compared each cycle
// against a slot-list reference model.
module tb_pipe_stage_reg;

    localparam int NI = 3;
    localparam logic [3:0] KM = 4'b1001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, stall, flush, validIn, cntClr;
    logic [3:0]  ctrlIn;
    logic [31:0] dataIn;

    logic        voA, voB, voC;
    logic [3:0]  coA, coB, coC;
    logic [31:0] doA, doB, doC;
    logic [15:0] scA, fcA, scB, fcB;
    logic [1:0]  scC, fcC;

    pipe_stage_reg #(.CTRL_W(4), .DATA_W(32), .DEPTH(1), .KILL_MASK(4'b1001), .CNT_W(16)) dutA (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_in(validIn),
        .ctrl_in(ctrlIn), .data_in(dataIn), .cnt_clr(cntClr), .valid_out(voA),
        .ctrl_out(coA), .data_out(doA), .stall_cnt(scA), .flush_cnt(fcA));

    pipe_stage_reg #(.CTRL_W(4), .DATA_W(32), .DEPTH(2), .KILL_MASK(4'b1001), .CNT_W(16)) dutB (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_in(validIn),
        .ctrl_in(ctrlIn), .data_in(dataIn), .cnt_clr(cntClr), .valid_out(voB),
        .ctrl_out(coB), .data_out(doB), .stall_cnt(scB), .flush_cnt(fcB));

    pipe_stage_reg #(.CTRL_W(4), .DATA_W(32), .DEPTH(3), .KILL_MASK(4'b1001), .CNT_W(2)) dutC (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_in(validIn),
        .ctrl_in(ctrlIn), .data_in(dataIn), .cnt_clr(cntClr), .valid_out(voC),
        .ctrl_out(coC), .data_out(doC), .stall_cnt(scC), .flush_cnt(fcC));

    // Reference model: each instance is a list of slots, index 0 nearest input.
    int          depthOf [NI] = '{1, 2, 3};
    int          cntMax  [NI] = '{65535, 65535, 3};
    logic        mVld  [NI][4];
    logic [3:0]  mCtrl [NI][4];
    logic [31:0] mData [NI][4];
    int          mStall [NI];
    int          mFlush [NI];

    int nCmp = 0;
    int nBad = 0;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCmp++;
        if (obs !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void modelReset();
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < 4; k++) begin
                mVld[i][k]  = 1'b0;
                mCtrl[i][k] = 4'h0;
                mData[i][k] = 32'h0;
            end
            mStall[i] = 0;
            mFlush[i] = 0;
        end
    endfunction

    function automatic void modelEdge();
        for (int i = 0; i < NI; i++) begin
            if (cntClr) begin
                mStall[i] = 0;
                mFlush[i] = 0;
            end else if (flush) begin
                if (mFlush[i] < cntMax[i]) mFlush[i]++;
            end else if (stall) begin
                if (mStall[i] < cntMax[i]) mStall[i]++;
            end
            if (flush || !stall) begin
                // Shift the slot list by one; a flush kills every slot it moves.
                for (int k = depthOf[i] - 1; k >= 1; k--) begin
                    mVld[i][k]  = flush ? 1'b0 : mVld[i][k-1];
                    mCtrl[i][k] = flush ? (mCtrl[i][k-1] & ~KM) : mCtrl[i][k-1];
                    mData[i][k] = mData[i][k-1];
                end
                mVld[i][0]  = flush ? 1'b0 : validIn;
                mCtrl[i][0] = (flush || !validIn) ? (ctrlIn & ~KM) : ctrlIn;
                mData[i][0] = dataIn;
            end
        end
    endfunction

    task automatic checkInst(input string tag, input int i, input logic v, input logic [3:0] c,
                             input logic [31:0] d, input logic [15:0] s, input logic [15:0] f);
        int last;
        last = depthOf[i] - 1;
        checkVal($sformatf("%s/%0d/vld", tag, i), 64'(v), 64'(mVld[i][last]));
        checkVal($sformatf("%s/%0d/ctrl", tag, i), 64'(c), 64'(mCtrl[i][last]));
        checkVal($sformatf("%s/%0d/data", tag, i), 64'(d), 64'(mData[i][last]));
        checkVal($sformatf("%s/%0d/stallCnt", tag, i), 64'(s), 64'(mStall[i]));
        checkVal($sformatf("%s/%0d/flushCnt", tag, i), 64'(f), 64'(mFlush[i]));
        if (!v) checkVal($sformatf("%s/%0d/bubbleInv", tag, i), 64'(c & KM), 64'(0));
    endtask

    task automatic checkAll(input string tag);
        checkInst(tag, 0, voA, coA, doA, scA, fcA);
        checkInst(tag, 1, voB, coB, doB, scB, fcB);
        checkInst(tag, 2, voC, coC, doC, {14'b0, scC}, {14'b0, fcC});
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkAll(tag);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; validIn = 1'b0; cntClr = 1'b0;
        ctrlIn = 4'h0; dataIn = 32'h0;
        modelReset();
        repeat (2) @(negedge clk);
        checkAll("reset");
        rst_n = 1'b1;

        // Pass-through on DEPTH=1
        validIn = 1'b1; ctrlIn = 4'hB; dataIn = 32'hDEADBEEF;
        step("pass");
        checkVal("pass/voA", 64'(voA), 64'(1));
        checkVal("pass/coA", 64'(coA), 64'(4'hB));
        checkVal("pass/doA", 64'(doA), 64'(32'hDEADBEEF));

        // Bubble insertion
        validIn = 1'b0; ctrlIn = 4'hF; dataIn = 32'h12345678;
        step("bubble");
        checkVal("bubble/voA", 64'(voA), 64'(0));
        checkVal("bubble/coA", 64'(coA), 64'(4'h6));

        // Stall holds contents while inputs change
        validIn = 1'b1; ctrlIn = 4'h9; dataIn = 32'h1;
        step("load");
        stall = 1'b1;
        for (int n = 0; n < 3; n++) begin
            validIn = 1'($urandom); ctrlIn = 4'($urandom); dataIn = $urandom;
            step("stall");
        end
        checkVal("stall/coA", 64'(coA), 64'(4'h9));
        checkVal("stall/doA", 64'(doA), 64'(32'h1));
        checkVal("stall/scA", 64'(scA), 64'(3));

        // Flush wins over stall
        stall = 1'b0; validIn = 1'b1; ctrlIn = 4'hF;
        step("fill");
        step("fill");
        stall = 1'b1; flush = 1'b1; ctrlIn = 4'h9;
        step("flushStall");
        checkVal("flush/voB", 64'(voB), 64'(0));
        checkVal("flush/coB", 64'(coB), 64'(4'h6));
        checkVal("flush/fcB", 64'(fcB), 64'(1));
        checkVal("flush/scB", 64'(scB), 64'(3));
        checkVal("flush/voA", 64'(voA), 64'(0));
        checkVal("flush/coA", 64'(coA), 64'(4'h0));
        stall = 1'b0; flush = 1'b0; validIn = 1'b0; ctrlIn = 4'h0;
        step("afterFlush");
        checkVal("flush2/voB", 64'(voB), 64'(0));
        checkVal("flush2/coB", 64'(coB), 64'(4'h0));

        // Counter saturation and clear-over-increment on 2-bit counters
        cntClr = 1'b1;
        step("clr");
        checkVal("clr/scC", 64'(scC), 64'(0));
        cntClr = 1'b0; stall = 1'b1;
        for (int n = 0; n < 5; n++) step("sat");
        checkVal("sat/scC", 64'(scC), 64'(3));
        cntClr = 1'b1;
        step("clrStall");
        checkVal("clrStall/scC", 64'(scC), 64'(0));
        cntClr = 1'b0; stall = 1'b0;

        // Asynchronous reset while full of valid slots
        validIn = 1'b1; ctrlIn = 4'hF;
        for (int n = 0; n < 3; n++) begin
            dataIn = $urandom;
            step("prefill");
        end
        checkVal("prefill/voA", 64'(voA), 64'(1));
        checkVal("prefill/coA", 64'(coA), 64'(4'hF));
        #2 rst_n = 1'b0;
        #1 modelReset();
        checkAll("asyncRst");
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            stall   = ($urandom_range(0, 3) == 0);
            flush   = ($urandom_range(0, 9) == 0);
            cntClr  = ($urandom_range(0, 39) == 0);
            validIn = 1'($urandom);
            ctrlIn  = 4'($urandom);
            dataIn  = $urandom;
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
